// File: rtl/wash_sensor_cond_pkg.sv
// Shared defaults and start-handshake state encodings for the wash input-conditioning block.
package wash_sensor_cond_pkg;
  localparam int         DEB_CYCLES_DEF = 16;
  localparam logic [7:0] COLD_ON_DEF    = 8'd40;
  localparam logic [7:0] COLD_OFF_DEF   = 8'd48;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
endpackage

// File: rtl/wash_sensor_cond_debounce.sv
// Two-flop synchroniser followed by a stability counter; clean flips only after
// DEB_CYCLES consecutive cycles of disagreement with the synchronised input.
module sensor_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/wash_sensor_cond.sv
// Conditions button, level probes and temperature for wash_fsm: debounce,
// cold hysteresis, held start request and sticky probe-plausibility fault.
module wash_sensor_cond
  import wash_sensor_cond_pkg::*;
#(
  parameter int                DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int                TEMP_W     = 8,
  parameter logic [TEMP_W-1:0] COLD_ON    = TEMP_W'(COLD_ON_DEF),
  parameter logic [TEMP_W-1:0] COLD_OFF   = TEMP_W'(COLD_OFF_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn_raw,
  input  logic              level_hi_raw,
  input  logic              level_lo_raw,
  input  logic [TEMP_W-1:0] temp_code,
  input  logic              fsm_ready,
  output logic              start,
  output logic              full,
  output logic              empty,
  output logic              cold,
  output logic              sensor_fault
);
  logic              btn_clean, hi_clean, lo_clean, btn_prev;
  logic [TEMP_W-1:0] temp_q;
  logic              temp_vld;
  logic [1:0]        state, state_nxt;
  logic              btn_rise, fault_set, fault_nxt;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk(clk), .reset(reset), .raw(start_btn_raw), .clean(btn_clean));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hi (
    .clk(clk), .reset(reset), .raw(level_hi_raw), .clean(hi_clean));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_lo (
    .clk(clk), .reset(reset), .raw(level_lo_raw), .clean(lo_clean));

  assign btn_rise  = btn_clean & ~btn_prev;
  // High probe wet while low probe dry cannot happen with a healthy drum.
  assign fault_set = hi_clean & ~lo_clean;
  assign fault_nxt = sensor_fault | fault_set;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (btn_rise && fsm_ready && !fault_nxt) state_nxt = ST_REQ;
      ST_REQ:       if (fault_nxt)       state_nxt = ST_IDLE;
                    else if (!fsm_ready) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (fsm_ready)       state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      btn_prev     <= 1'b0;
      temp_q       <= '0;
      temp_vld     <= 1'b0;
      cold         <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      state        <= state_nxt;
      btn_prev     <= btn_clean;
      temp_q       <= temp_code;
      temp_vld     <= 1'b1;
      sensor_fault <= fault_nxt;
      // Skip the first cycle after reset so the cleared temp_q never looks cold.
      if (temp_vld) begin
        if (temp_q < COLD_ON)        cold <= 1'b1;
        else if (temp_q >= COLD_OFF) cold <= 1'b0;
      end
    end
  end

  assign start = (state == ST_REQ);
  assign full  = hi_clean;
  assign empty = ~lo_clean;
endmodule

// File: tb/tb_wash_sensor_cond.sv
// Directed bench for wash_sensor_cond with DEB_CYCLES=4; inputs change 1 ns after an edge.
module tb_wash_sensor_cond;
  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn_raw, level_hi_raw, level_lo_raw, fsm_ready;
  logic [7:0] temp_code;
  logic       start, full, empty, cold, sensor_fault;
  int         checks = 0;
  int         errors = 0;
  logic       seen;

  wash_sensor_cond #(.DEB_CYCLES(4), .TEMP_W(8), .COLD_ON(8'd40), .COLD_OFF(8'd48)) dut (
    .clk(clk), .reset(reset), .start_btn_raw(start_btn_raw),
    .level_hi_raw(level_hi_raw), .level_lo_raw(level_lo_raw),
    .temp_code(temp_code), .fsm_ready(fsm_ready), .start(start),
    .full(full), .empty(empty), .cold(cold), .sensor_fault(sensor_fault));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n edges, OR-ing start into seen after each.
  task automatic tick_start(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      seen = seen | start;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start_btn_raw = 1'b0; level_hi_raw = 1'b0; level_lo_raw = 1'b0;
    fsm_ready = 1'b1; temp_code = 8'd50; seen = 1'b0;
    tick(2);
    chk("rst_start", start, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_cold", cold, 0);
    chk("rst_fault", sensor_fault, 0);
    reset = 1'b0;
    tick(3);
    chk("cold_after_rel", cold, 0);

    // glitch rejection on the low probe
    level_lo_raw = 1'b1;
    tick(8);
    chk("lo_settle_empty", empty, 0);
    level_lo_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) level_lo_raw = 1'b1;
      tick(1);
      seen = seen | empty;
    end
    chk("glitch3_empty", seen, 0);
    level_lo_raw = 1'b0;
    tick(4);
    level_lo_raw = 1'b1;
    tick(1);
    chk("glitch4_m5", empty, 0);
    tick(1);
    chk("glitch4_m6", empty, 1);
    tick(3);
    chk("glitch4_m9", empty, 1);
    tick(1);
    chk("glitch4_m10", empty, 0);

    // high probe latency: exactly 6 edges
    tick(4);
    level_hi_raw = 1'b1;
    tick(5);
    chk("hi_lat_n5", full, 0);
    tick(1);
    chk("hi_lat_n6", full, 1);
    chk("no_fault_wet", sensor_fault, 0);

    // cold hysteresis
    temp_code = 8'd39;
    tick(1);
    chk("cold_39_t1", cold, 0);
    tick(1);
    chk("cold_39_t2", cold, 1);
    temp_code = 8'd45;
    tick(3);
    chk("cold_45_hold1", cold, 1);
    temp_code = 8'd48;
    tick(1);
    chk("cold_48_t1", cold, 1);
    tick(1);
    chk("cold_48_t2", cold, 0);
    temp_code = 8'd45;
    tick(3);
    chk("cold_45_hold0", cold, 0);
    temp_code = 8'd40;
    tick(3);
    chk("cold_40_hold0", cold, 0);
    temp_code = 8'd30;
    tick(2);
    chk("cold_30", cold, 1);

    // start handshake
    start_btn_raw = 1'b1;
    tick(6);
    chk("start_b6", start, 0);
    tick(1);
    chk("start_b7", start, 1);
    tick(3);
    start_btn_raw = 1'b0;
    chk("start_hold_req", start, 1);
    fsm_ready = 1'b0;
    tick(1);
    chk("start_accepted", start, 0);
    start_btn_raw = 1'b1;
    seen = 1'b0;
    tick_start(10);
    start_btn_raw = 1'b0;
    tick_start(10);
    chk("press_not_ready", seen, 0);
    fsm_ready = 1'b1;
    tick(2);
    chk("idle_no_start", start, 0);
    start_btn_raw = 1'b1;
    tick(7);
    chk("second_press", start, 1);
    seen = 1'b0;
    tick_start(0);

    // reset while requesting (button still held, cold=1, full=1, empty=0)
    reset = 1'b1;
    tick(1);
    chk("midrst_start", start, 0);
    chk("midrst_full", full, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_cold", cold, 0);
    reset = 1'b0;
    start_btn_raw = 1'b0;
    temp_code = 8'd50;
    tick(10);
    chk("post_rst_idle", start, 0);
    start_btn_raw = 1'b1;
    tick(7);
    chk("post_rst_press", start, 1);
    fsm_ready = 1'b0;
    tick(1);
    fsm_ready = 1'b1;
    start_btn_raw = 1'b0;
    tick(10);

    // probe fault
    chk("pre_fault", sensor_fault, 0);
    level_lo_raw = 1'b0;
    tick(6);
    chk("fault_f6_full", full, 1);
    chk("fault_f6_empty", empty, 1);
    chk("fault_f6", sensor_fault, 0);
    tick(1);
    chk("fault_f7", sensor_fault, 1);
    level_lo_raw = 1'b1;
    tick(10);
    chk("fault_sticky", sensor_fault, 1);
    chk("fault_empty_pass", empty, 0);
    start_btn_raw = 1'b1;
    seen = 1'b0;
    tick_start(10);
    start_btn_raw = 1'b0;
    tick_start(2);
    chk("fault_no_start", seen, 0);
    reset = 1'b1;
    tick(1);
    chk("fault_cleared", sensor_fault, 0);
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
